// File: rtl/shot_pkg.sv
// -----------------------------------------------------------------------------
// shot_pkg
// Shared types and constants for the player shot controller.
//   state_t  : frame-sequencer states (WAIT_FRAME -> MOVE -> LAUNCH)
//   coord_t  : signed 11-bit screen coordinate
//   SHOT_W   : shot sprite width in pixels (fixed)
//   launch_x : horizontal launch position centred on the 32-pixel player sprite
// -----------------------------------------------------------------------------
package shot_pkg;

  localparam int COORD_W  = 11;
  localparam int SHOT_W   = 4;
  localparam int SPRITE_W = 32;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    MOVE       = 2'd1,
    LAUNCH     = 2'd2
  } state_t;

  // Shot is centred on the player sprite: 32/2 - 4/2 = 14 pixels right of its left edge.
  function automatic coord_t launch_x(input coord_t player_x);
    return player_x + coord_t'(SPRITE_W / 2 - SHOT_W / 2);
  endfunction

endpackage

// File: rtl/shot_slot_finder.sv
// -----------------------------------------------------------------------------
// shot_slot_finder
// Combinational priority encoder returning the lowest-index free shot slot.
// Ports:
//   busy  [N-1:0]     in  : slot occupied flags
//   found             out : at least one slot is free
//   index [IDX_W-1:0] out : lowest free slot (0 when none is free)
// -----------------------------------------------------------------------------
module shot_slot_finder #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     busy,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/player_shot_controller.sv
// -----------------------------------------------------------------------------
// player_shot_controller
// Manages a small pool of player shots: launches a shot above the player on a
// fire key press, moves all shots upward once per video frame, retires shots
// that leave the top of the screen or are reported as hit.
//
// Parameters:
//   SHOT_COUNT      number of shot slots
//   COOLDOWN_FRAMES frames that must elapse between launches
//   SHOT_SPEED      upward pixels per frame
//   SHOT_H          shot height in pixels (width is fixed at 4)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   startOfFrame               one-cycle pulse per video frame
//   fireIsPress                fire key level
//   playerTopLeftX/Y           player sprite position (32x32)
//   shotHit[SHOT_COUNT]        per-slot collision pulse
//   shotActive[SHOT_COUNT]     slot occupied
//   shotTopLeftX/Y[SHOT_COUNT] per-slot position (qualify with shotActive)
//   fireStrobe                 one-cycle pulse, coincident with the new slot
//                              first showing active
// Build option:
//   AUTO_FIRE_EN  when defined, a held fire key re-arms the request every frame
//                 so it refires as soon as the cooldown allows.
// -----------------------------------------------------------------------------
module player_shot_controller
  import shot_pkg::*;
#(
  parameter int SHOT_COUNT      = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SHOT_SPEED      = 4,
  parameter int SHOT_H          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic                  fireIsPress,
  input  coord_t                playerTopLeftX,
  input  coord_t                playerTopLeftY,
  input  logic [SHOT_COUNT-1:0] shotHit,
  output logic [SHOT_COUNT-1:0] shotActive,
  output coord_t                shotTopLeftX [SHOT_COUNT],
  output coord_t                shotTopLeftY [SHOT_COUNT],
  output logic                  fireStrobe
);

  localparam int IDX_W = (SHOT_COUNT > 1) ? $clog2(SHOT_COUNT) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  state_t          state_reg, state_next;
  logic            fire_prev_reg;
  logic            pending_reg, pending_next;
  logic [CD_W-1:0] cooldown_reg, cooldown_next;
  logic            cool_ready_reg, cool_ready_next;
  logic            strobe_reg;

  logic             fire_rise;
  logic             move_now;
  logic             launch_ok;
  logic             slot_found;
  logic [IDX_W-1:0] slot_idx;
  coord_t           launch_pos_x;
  coord_t           launch_pos_y;

  assign fire_rise    = fireIsPress & ~fire_prev_reg;
  assign move_now     = (state_reg == MOVE);
  assign launch_pos_x = launch_x(playerTopLeftX);
  assign launch_pos_y = playerTopLeftY - coord_t'(SHOT_H);

  // A slot being hit in the LAUNCH cycle is still marked active here, so it
  // cannot be handed out again in the same frame.
  shot_slot_finder #(
    .N     (SHOT_COUNT),
    .IDX_W (IDX_W)
  ) u_finder (
    .busy  (shotActive),
    .found (slot_found),
    .index (slot_idx)
  );

  // ---------------------------------------------------------------------------
  // Frame sequencer and launch control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= WAIT_FRAME;
      fire_prev_reg  <= 1'b0;
      pending_reg    <= 1'b0;
      cooldown_reg   <= '0;
      cool_ready_reg <= 1'b0;
      strobe_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fire_prev_reg  <= fireIsPress;
      pending_reg    <= pending_next;
      cooldown_reg   <= cooldown_next;
      cool_ready_reg <= cool_ready_next;
      strobe_reg     <= launch_ok;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg | fire_rise;
    cooldown_next   = cooldown_reg;
    cool_ready_next = cool_ready_reg;
    launch_ok       = 1'b0;

    case (state_reg)
      WAIT_FRAME: begin
        if (startOfFrame) state_next = MOVE;
      end

      MOVE: begin
        state_next = LAUNCH;
        // Readiness is judged on the value before this frame's decrement, so
        // the frame that counts 1 -> 0 is still a cooldown frame and exactly
        // COOLDOWN_FRAMES frames separate two launches.
        cool_ready_next = (cooldown_reg == '0);
        if (cooldown_reg != '0) cooldown_next = cooldown_reg - 1'b1;
      end

      LAUNCH: begin
        state_next = WAIT_FRAME;
        launch_ok  = pending_reg && cool_ready_reg && slot_found &&
                     (playerTopLeftY >= coord_t'(SHOT_H));
        // The request is consumed whether or not it launched; only an edge
        // arriving in this very cycle survives into the next frame.
`ifdef AUTO_FIRE_EN
        pending_next = fire_rise | fireIsPress;
`else
        pending_next = fire_rise;
`endif
        if (launch_ok) cooldown_next = CD_W'(COOLDOWN_FRAMES);
      end

      default: state_next = WAIT_FRAME;
    endcase
  end

  assign fireStrobe = strobe_reg;

  // ---------------------------------------------------------------------------
  // Per-slot state: hit clears first, then frame motion, then launch fill.
  // A launch only ever targets an inactive slot, so it never competes with the
  // hit or motion branches of the same slot.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SHOT_COUNT; gi++) begin : g_slot
    logic   active_reg, active_next;
    coord_t x_reg, x_next;
    coord_t y_reg, y_next;

    always_comb begin
      active_next = active_reg;
      x_next      = x_reg;
      y_next      = y_reg;
      if (active_reg && shotHit[gi]) begin
        active_next = 1'b0;
      end else if (move_now && active_reg) begin
        if (y_reg < coord_t'(SHOT_SPEED)) active_next = 1'b0;
        else                               y_next      = y_reg - coord_t'(SHOT_SPEED);
      end else if (launch_ok && (slot_idx == IDX_W'(gi))) begin
        active_next = 1'b1;
        x_next      = launch_pos_x;
        y_next      = launch_pos_y;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        active_reg <= 1'b0;
        x_reg      <= '0;
        y_reg      <= '0;
      end else begin
        active_reg <= active_next;
        x_reg      <= x_next;
        y_reg      <= y_next;
      end
    end

    assign shotActive[gi]   = active_reg;
    assign shotTopLeftX[gi] = x_reg;
    assign shotTopLeftY[gi] = y_reg;
  end

endmodule

// File: tb/tb_player_shot_controller.sv
// -----------------------------------------------------------------------------
// tb_player_shot_controller
// Directed stimulus for player_shot_controller with a frame-level reference
// model checked every cycle, plus literal expectations for key scenarios.
// Honour AUTO_FIRE_EN the same way as the design when it is defined.
// -----------------------------------------------------------------------------
module tb_player_shot_controller;

  localparam int N        = 4;
  localparam int COOLDOWN = 8;
  localparam int SPEED    = 4;
  localparam int SHOT_H   = 8;
  localparam int X_OFFSET = 14;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sof = 1'b0;
  logic                fire = 1'b0;
  logic signed [10:0]  px = 11'sd100;
  logic signed [10:0]  py = 11'sd200;
  logic [N-1:0]        hit = '0;
  logic [N-1:0]        active;
  logic signed [10:0]  sx [N];
  logic signed [10:0]  sy [N];
  logic                strobe;

  always #5 clk = ~clk;

  player_shot_controller #(
    .SHOT_COUNT      (N),
    .COOLDOWN_FRAMES (COOLDOWN),
    .SHOT_SPEED      (SPEED),
    .SHOT_H          (SHOT_H)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (sof),
    .fireIsPress    (fire),
    .playerTopLeftX (px),
    .playerTopLeftY (py),
    .shotHit        (hit),
    .shotActive     (active),
    .shotTopLeftX   (sx),
    .shotTopLeftY   (sy),
    .fireStrobe     (strobe)
  );

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int printed = 0;

  // ---------------------------------------------------------------------------
  // Reference model. Frame phase is tracked as "cycles since the accepted
  // frame pulse"; cooldown is expressed as a distance between frame numbers.
  // ---------------------------------------------------------------------------
  bit [N-1:0] m_act = '0;
  int         m_x [N];
  int         m_y [N];
  bit         m_strobe = 1'b0;
  bit         m_pending = 1'b0;
  bit         m_prev = 1'b0;
  int         m_age = -1;
  int         m_frame = 0;
  int         m_last = -1000;
  bit [N-1:0] m_pre;
  bit         m_rise;
  int         m_pick;
  bit         m_ok;

  always @(posedge clk) begin
    if (reset) begin
      m_act = '0;
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0;
        m_y[i] = 0;
      end
      m_strobe  = 1'b0;
      m_pending = 1'b0;
      m_prev    = 1'b0;
      m_age     = -1;
      m_frame   = 0;
      m_last    = -1000;
    end else begin
      m_rise   = fire && !m_prev;
      m_prev   = fire;
      m_strobe = 1'b0;
      m_pre    = m_act;
      m_act    = m_act & ~hit;
      if (m_age == 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_act[i]) begin
            if (m_y[i] < SPEED) m_act[i] = 1'b0;
            else                m_y[i]   = m_y[i] - SPEED;
          end
        end
      end
      if (m_age == 1) begin
        m_pick = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_pre[i]) m_pick = i;
        if (m_pending && (m_frame - m_last >= COOLDOWN + 1) &&
            (int'(py) >= SHOT_H) && (m_pick >= 0)) begin
          m_act[m_pick] = 1'b1;
          m_x[m_pick]   = int'(px) + X_OFFSET;
          m_y[m_pick]   = int'(py) - SHOT_H;
          m_last        = m_frame;
          m_strobe      = 1'b1;
        end
`ifdef AUTO_FIRE_EN
        m_pending = m_rise || fire;
`else
        m_pending = m_rise;
`endif
      end else if (m_rise) begin
        m_pending = 1'b1;
      end
      if (m_age == 1)      m_age = -1;
      else if (m_age == 0) m_age = 1;
      else if (sof) begin
        m_age   = 0;
        m_frame = m_frame + 1;
      end
    end

    #1;
    if (strobe === 1'b1) strobe_cnt++;
    m_ok = (active === m_act) && (strobe === m_strobe);
    for (int i = 0; i < N; i++)
      if (int'(sx[i]) != m_x[i] || int'(sy[i]) != m_y[i]) m_ok = 1'b0;
    tests++;
    if (!m_ok) begin
      fails++;
      if (printed < 10) begin
        printed++;
        $display("FAIL cycle_model t=%0t active=%b want %b strobe=%b want %b y0..3=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                 $time, active, m_act, strobe, m_strobe, sy[0], sy[1], sy[2], sy[3],
                 m_y[0], m_y[1], m_y[2], m_y[3]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, act);
    end
  endtask

  task automatic press();
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic idle_frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  int s;
  int launch_frames[$];

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_active", int'(active), 0);
    check("reset_x0", int'(sx[0]), 0);
    check("reset_strobe", int'(strobe), 0);

    // Single press at (100,200).
    press();
    s = strobe_cnt;
    frame();
    check("first_active", int'(active), 1);
    check("first_x0", int'(sx[0]), 114);
    check("first_y0", int'(sy[0]), 192);
    check("first_strobes", strobe_cnt - s, 1);
    frame();
    check("first_move_y0", int'(sy[0]), 188);

    // Fill the remaining slots, one launch per cooldown window.
    for (int k = 0; k < 3; k++) begin
      idle_frames(9);
      press();
      frame();
    end
    check("fill_active", int'(active), 15);
    check("fill_y3", int'(sy[3]), 192);

    // All busy: request dropped.
    idle_frames(9);
    press();
    s = strobe_cnt;
    frame();
    check("full_active", int'(active), 15);
    check("full_strobes", strobe_cnt - s, 0);

    // Hit slot 2, then relaunch into it.
    @(negedge clk) hit = 4'b0100;
    @(negedge clk) hit = 4'b0000;
    check("hit2_active", int'(active), 11);
    press();
    s = strobe_cnt;
    frame();
    check("relaunch_active", int'(active), 15);
    check("relaunch_x2", int'(sx[2]), 114);
    check("relaunch_y2", int'(sy[2]), 192);
    check("relaunch_strobes", strobe_cnt - s, 1);

    // Top-of-screen retirement.
    pulse_reset();
    check("reset2_active", int'(active), 0);
    py = 11'sd11;
    press();
    frame();
    check("y3_launch_y0", int'(sy[0]), 3);
    frame();
    check("y3_retired", int'(active), 0);
    idle_frames(9);
    py = 11'sd12;
    press();
    frame();
    check("y4_launch_y0", int'(sy[0]), 4);
    frame();
    check("y4_moved_y0", int'(sy[0]), 0);
    check("y4_moved_active", int'(active), 1);
    frame();
    check("y4_retired", int'(active), 0);

    // Player too close to the top: dropped.
    idle_frames(9);
    py = 11'sd7;
    press();
    s = strobe_cnt;
    frame();
    check("lowy_active", int'(active), 0);
    check("lowy_strobes", strobe_cnt - s, 0);

    // Reset asserted during LAUNCH with a pending request.
    py = 11'sd200;
    idle_frames(9);
    press();
    frame();
    check("pre_abort_active", int'(active), 1);
    idle_frames(9);
    press();
    s = strobe_cnt;
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("abort_active", int'(active), 0);
    check("abort_x0", int'(sx[0]), 0);
    check("abort_y0", int'(sy[0]), 0);
    check("abort_strobe", int'(strobe), 0);
    check("abort_strobes", strobe_cnt - s, 0);
    reset = 1'b0;

    // Fire held for 40 frames.
    py = 11'sd40;
    @(negedge clk) fire = 1'b1;
    for (int f = 1; f <= 40; f++) begin
      s = strobe_cnt;
      frame();
      if (strobe_cnt != s) launch_frames.push_back(f);
    end
    fire = 1'b0;
`ifdef AUTO_FIRE_EN
    check("hold_launches", launch_frames.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("hold_frame%0d", k),
            (k < launch_frames.size()) ? launch_frames[k] : -1, 1 + 9 * k);
`else
    check("hold_launches", launch_frames.size(), 1);
    check("hold_first_frame", (launch_frames.size() > 0) ? launch_frames[0] : -1, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/player_shot_controller.md
PLAYER_SHOT_CONTROLLER -- requirements
Module: player_shot_controller

Interface
REQ-001 SHALL have parameter SHOT_COUNT, default 4, meaning number of player shot slots shared by the fire key.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 8, meaning minimum frames between launches.
REQ-003 SHALL have parameter SHOT_SPEED, default 4, meaning upward pixels moved per frame.
REQ-004 SHALL have parameter SHOT_H, default 8, meaning shot height in pixels; shot width is fixed at 4.
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port startOfFrame  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port fireIsPress  input  1  level, fire key held.
REQ-009 SHALL have ports playerTopLeftX / playerTopLeftY  input  11 signed each  player sprite position, 32x32 sprite.
REQ-010 SHALL have port shotHit  input  SHOT_COUNT  per-slot collision pulse.
REQ-011 SHALL have port shotActive  output  SHOT_COUNT  slot occupied.
REQ-012 SHALL have ports shotTopLeftX / shotTopLeftY  output  SHOT_COUNT x 11 signed  per-slot position.
REQ-013 SHALL have port fireStrobe  output  1  one-cycle pulse on each launch.

Function
REQ-014 SHALL run FSM WAIT_FRAME -> MOVE -> LAUNCH -> WAIT_FRAME; startOfFrame in cycle T gives MOVE at T+1, LAUNCH at T+2, WAIT_FRAME at T+3; startOfFrame outside WAIT_FRAME is ignored.
REQ-015 SHALL latch a pending-fire flag on the rising edge of fireIsPress in any state; pending clears in LAUNCH whether or not a launch occurs (no queuing across frames).
REQ-016 In MOVE, SHALL subtract SHOT_SPEED from Y of every active slot; a slot whose Y < SHOT_SPEED retires (shotActive=0) instead of moving.
REQ-017 In LAUNCH, SHALL launch into the lowest-index free slot when pending=1, cooldown=0, and playerTopLeftY >= SHOT_H; X = playerTopLeftX+14, Y = playerTopLeftY-SHOT_H; fireStrobe=1 that cycle.
REQ-018 SHALL drop the request without any state change other than clearing pending when all slots are busy or playerTopLeftY < SHOT_H.
REQ-019 SHALL load cooldown with COOLDOWN_FRAMES on launch and decrement it by 1 in MOVE when nonzero, saturating at 0.
REQ-020 SHALL clear shotActive[i] the cycle after shotHit[i]=1 in any state; a hit on an inactive slot is ignored; a hit coinciding with a MOVE retire clears the slot once; a hit on a slot in LAUNCH takes priority, so the slot is not reused that frame.
REQ-021 SHALL hold X/Y of inactive slots at their last value; consumers SHALL qualify them with shotActive.

Reset
REQ-022 On reset, SHALL set state=WAIT_FRAME, shotActive=0, all X/Y=0, cooldown=0, pending=0, fireStrobe=0, and the edge-detect register=0; reset mid-frame aborts MOVE/LAUNCH with no partial update.

Configuration
REQ-023 With AUTO_FIRE_EN defined, SHALL also set pending in LAUNCH whenever fireIsPress=1, so a held key refires every COOLDOWN_FRAMES+1 frames; without it, only rising edges fire.

Structure
REQ-024 SHALL place the FSM state enum, shot width constant and coordinate typedef (signed 11-bit) in package shot_pkg.
REQ-025 SHALL implement lowest-free-slot selection in sub-module shot_slot_finder (combinational priority encoder with found flag).

Verification
REQ-026 Press fire once, playerTopLeft=(100,200) -> after next frame slot0 active at (114,192), fireStrobe pulses once.
REQ-027 Hold fire 40 frames, no AUTO_FIRE_EN -> exactly one launch; with AUTO_FIRE_EN -> launches at frames 1,10,19,28,37 (5 shots, slots 0..3 then slot reuse after retire/hit).
REQ-028 Fill 4 slots, press fire -> no launch, no strobe; shotHit[2] pulse, press again after cooldown -> slot2 relaunched.
REQ-029 Shot at Y=3, SHOT_SPEED=4 -> retired in MOVE; shot at Y=4 -> moves to Y=0, retires next frame.
REQ-030 Assert reset during LAUNCH with pending=1 -> no launch, all outputs zero the next cycle.
